// File: rtl/mem_pkg.sv
// Shared memory-interface constants and the grant encoding used by the BRAM arbiter.
package mem_pkg;

    localparam int unsigned MEM_SIZE    = 512 * 424;
    localparam int unsigned MEM_LOGSIZE = 18;
    localparam int unsigned MEM_BITS    = 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_WR   = 2'b01,
        GNT_RD   = 2'b10
    } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter between a writer and a reader.
// The priority bit only moves on contention cycles; reset favours the writer.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       rd_req,
    output logic [1:0] gnt
);

    logic prio_wr_q;
    logic prio_wr_d;
    gnt_e gnt_sel;

    always_comb begin
        gnt_sel   = GNT_NONE;
        prio_wr_d = prio_wr_q;
        if (!reset) begin
            if (wr_req && rd_req) begin
                // The loser of this contention wins the next one.
                gnt_sel   = prio_wr_q ? GNT_WR : GNT_RD;
                prio_wr_d = !prio_wr_q;
            end else if (wr_req) begin
                gnt_sel = GNT_WR;
            end else if (rd_req) begin
                gnt_sel = GNT_RD;
            end
        end
    end

    assign gnt = gnt_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_wr_q <= 1'b1;
        end else begin
            prio_wr_q <= prio_wr_d;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port block RAM (1-cycle read latency) between a writer and a reader,
// tracks read-data validity and counts completed frames (writes to the last address).
module bram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned SIZE    = MEM_SIZE,
    parameter int unsigned LOGSIZE = MEM_LOGSIZE,
    parameter int unsigned BITS    = MEM_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_req,
    input  logic [LOGSIZE-1:0] wr_addr,
    input  logic [BITS-1:0]    wr_data,
    output logic               wr_ack,
    input  logic               rd_req,
    input  logic [LOGSIZE-1:0] rd_addr,
    output logic               rd_ack,
    output logic               rd_valid,
    output logic [BITS-1:0]    rd_data,
    output logic [LOGSIZE-1:0] mem_addr,
    output logic [BITS-1:0]    mem_din,
    output logic               mem_we,
    input  logic [BITS-1:0]    mem_dout,
    output logic               frame_done,
    output logic [7:0]         frame_count
);

    // One extra bit so SIZE itself is representable when SIZE == 2**LOGSIZE.
    localparam logic [LOGSIZE:0]   SIZE_W    = (LOGSIZE + 1)'(SIZE);
    localparam logic [LOGSIZE-1:0] LAST_ADDR = LOGSIZE'(SIZE - 1);

    logic [1:0] gnt;
    logic       wr_in_range;

    logic       rd_valid_q, rd_valid_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] frame_count_q, frame_count_d;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .wr_req (wr_req),
        .rd_req (rd_req),
        .gnt    (gnt)
    );

    always_comb begin
        wr_ack        = (gnt == GNT_WR);
        rd_ack        = (gnt == GNT_RD);
        wr_in_range   = ({1'b0, wr_addr} < SIZE_W);
        mem_addr      = wr_ack ? wr_addr : rd_addr;
        mem_din       = wr_data;
        mem_we        = wr_ack && wr_in_range;
        rd_valid_d    = rd_ack;
        frame_done_d  = wr_ack && (wr_addr == LAST_ADDR);
        frame_count_d = frame_done_d ? frame_count_q + 8'd1 : frame_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            rd_valid_q    <= rd_valid_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = mem_dout;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural 1-cycle-latency single-port RAM.
module tb_bram_arbiter;

    localparam int unsigned SIZE    = 512 * 424;
    localparam int unsigned LOGSIZE = 18;
    localparam int unsigned BITS    = 1;

    logic               clk;
    logic               reset;
    logic               wr_req;
    logic [LOGSIZE-1:0] wr_addr;
    logic [BITS-1:0]    wr_data;
    logic               wr_ack;
    logic               rd_req;
    logic [LOGSIZE-1:0] rd_addr;
    logic               rd_ack;
    logic               rd_valid;
    logic [BITS-1:0]    rd_data;
    logic [LOGSIZE-1:0] mem_addr;
    logic [BITS-1:0]    mem_din;
    logic               mem_we;
    logic [BITS-1:0]    mem_dout;
    logic               frame_done;
    logic [7:0]         frame_count;

    logic [BITS-1:0] mem [0:SIZE-1];

    int n_tests = 0;
    int n_fail  = 0;

    bram_arbiter #(
        .SIZE    (SIZE),
        .LOGSIZE (LOGSIZE),
        .BITS    (BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first single-port RAM.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are applied just after the falling edge; checks follow 1 time unit later.
    task automatic drive(input logic wr, input logic [LOGSIZE-1:0] wa, input logic [BITS-1:0] wd,
                         input logic rd, input logic [LOGSIZE-1:0] ra);
        @(negedge clk);
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rd;
        rd_addr = ra;
        #1;
    endtask

    initial begin
        logic [LOGSIZE-1:0] last;
        logic [LOGSIZE-1:0] oor;
        last = LOGSIZE'(SIZE - 1);
        oor  = LOGSIZE'(SIZE);

        reset = 1'b1;
        wr_req = 1'b1; wr_addr = 18'd3; wr_data = 1'b1;
        rd_req = 1'b1; rd_addr = 18'd3;
        @(negedge clk);
        #1;
        check("rst_wr_ack",      32'(wr_ack), 32'd0);
        check("rst_rd_ack",      32'(rd_ack), 32'd0);
        check("rst_mem_we",      32'(mem_we), 32'd0);
        check("rst_rd_valid",    32'(rd_valid), 32'd0);
        check("rst_frame_done",  32'(frame_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);

        // Contention straight out of reset: WR, RD, WR, RD.
        reset = 1'b0;
        wr_addr = 18'd10; wr_data = 1'b1; rd_addr = 18'd10;
        #1;
        check("c1_wr_ack",   32'(wr_ack), 32'd1);
        check("c1_rd_ack",   32'(rd_ack), 32'd0);
        check("c1_mem_we",   32'(mem_we), 32'd1);
        check("c1_rd_valid", 32'(rd_valid), 32'd0);
        drive(1'b1, 18'd10, 1'b1, 1'b1, 18'd10);
        check("c2_rd_ack",   32'(rd_ack), 32'd1);
        check("c2_wr_ack",   32'(wr_ack), 32'd0);
        check("c2_mem_addr", 32'(mem_addr), 32'd10);
        check("c2_mem_we",   32'(mem_we), 32'd0);
        check("c2_rd_valid", 32'(rd_valid), 32'd0);
        drive(1'b1, 18'd10, 1'b0, 1'b1, 18'd10);
        check("c3_wr_ack",   32'(wr_ack), 32'd1);
        check("c3_rd_valid", 32'(rd_valid), 32'd1);
        check("c3_rd_data",  32'(rd_data), 32'd1);
        drive(1'b1, 18'd10, 1'b0, 1'b1, 18'd10);
        check("c4_rd_ack",   32'(rd_ack), 32'd1);
        check("c4_rd_valid", 32'(rd_valid), 32'd0);
        drive(1'b0, 18'd10, 1'b1, 1'b0, 18'd33);
        check("c5_rd_valid", 32'(rd_valid), 32'd1);
        check("c5_rd_data",  32'(rd_data), 32'd0);
        check("c5_acks",     32'({wr_ack, rd_ack}), 32'd0);
        check("idle_addr",   32'(mem_addr), 32'd33);
        check("idle_din",    32'(mem_din), 32'd1);
        check("idle_we",     32'(mem_we), 32'd0);

        // Writer alone, then read-back.
        drive(1'b1, 18'd5, 1'b1, 1'b0, 18'd0);
        check("w5_wr_ack",   32'(wr_ack), 32'd1);
        check("w5_rd_ack",   32'(rd_ack), 32'd0);
        check("w5_mem_we",   32'(mem_we), 32'd1);
        check("w5_mem_addr", 32'(mem_addr), 32'd5);
        check("w5_mem_din",  32'(mem_din), 32'd1);
        drive(1'b0, 18'd0, 1'b0, 1'b1, 18'd5);
        check("r5_rd_ack",   32'(rd_ack), 32'd1);
        check("r5_wr_ack",   32'(wr_ack), 32'd0);
        check("r5_mem_addr", 32'(mem_addr), 32'd5);
        check("r5_mem_we",   32'(mem_we), 32'd0);
        drive(1'b0, 18'd0, 1'b0, 1'b0, 18'd0);
        check("r5_rd_valid", 32'(rd_valid), 32'd1);
        check("r5_rd_data",  32'(rd_data), 32'd1);
        drive(1'b0, 18'd0, 1'b0, 1'b0, 18'd0);
        check("idle_rd_valid", 32'(rd_valid), 32'd0);

        // Single requests must not move the round-robin pointer.
        drive(1'b0, 18'd0, 1'b0, 1'b1, 18'd0);
        check("rr_rd_only", 32'(rd_ack), 32'd1);
        drive(1'b1, 18'd20, 1'b0, 1'b1, 18'd0);
        check("rr_cont_wr", 32'(wr_ack), 32'd1);
        check("rr_cont_wr_rd", 32'(rd_ack), 32'd0);
        drive(1'b0, 18'd0, 1'b0, 1'b1, 18'd0);
        check("rr_rd_only2", 32'(rd_ack), 32'd1);
        drive(1'b1, 18'd20, 1'b0, 1'b1, 18'd0);
        check("rr_cont_rd", 32'(rd_ack), 32'd1);
        check("rr_cont_rd_wr", 32'(wr_ack), 32'd0);
        drive(1'b1, 18'd20, 1'b0, 1'b0, 18'd0);
        check("no_starve_wr", 32'(wr_ack), 32'd1);

        // Out-of-range write.
        drive(1'b1, oor, 1'b1, 1'b0, 18'd0);
        check("oor_wr_ack",   32'(wr_ack), 32'd1);
        check("oor_mem_we",   32'(mem_we), 32'd0);
        check("oor_mem_addr", 32'(mem_addr), 32'(SIZE));
        drive(1'b0, 18'd0, 1'b0, 1'b0, 18'd0);
        check("oor_frame_done",  32'(frame_done), 32'd0);
        check("oor_frame_count", 32'(frame_count), 32'd0);

        // 256 writes to the last address wrap the frame counter.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, last, 1'b1, 1'b0, 18'd0);
            check("fr_mem_we", 32'(mem_we), 32'd1);
            if (i > 0) begin
                check("fr_done",  32'(frame_done), 32'd1);
                check("fr_count", 32'(frame_count), 32'(i));
            end
        end
        drive(1'b0, 18'd0, 1'b0, 1'b0, 18'd0);
        check("fr_last_done",  32'(frame_done), 32'd1);
        check("fr_wrap_count", 32'(frame_count), 32'd0);
        drive(1'b0, 18'd0, 1'b0, 1'b0, 18'd0);
        check("fr_done_low", 32'(frame_done), 32'd0);

        // Reset in the cycle a read is requested.
        drive(1'b1, last, 1'b0, 1'b0, 18'd0);
        drive(1'b0, 18'd0, 1'b0, 1'b1, 18'd5);
        check("pre_rst_count", 32'(frame_count), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_rd_ack_n", 32'(rd_ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_req = 1'b0;
        #1;
        check("rst_rd_valid_n1",   32'(rd_valid), 32'd0);
        check("rst_frame_count_n1", 32'(frame_count), 32'd0);
        check("rst_frame_done_n1", 32'(frame_done), 32'd0);
        drive(1'b1, 18'd7, 1'b0, 1'b1, 18'd7);
        check("rst_rr_wr", 32'(wr_ack), 32'd1);
        check("rst_rr_rd", 32'(rd_ack), 32'd0);
        drive(1'b0, 18'd0, 1'b0, 1'b0, 18'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 512*424, meaning number of memory words.
REQ-002 SHALL have parameter LOGSIZE, default 18, meaning address width.
REQ-003 SHALL have parameter BITS, default 1, meaning data word width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_req  input  1  the writer requests one write this cycle.
REQ-007 SHALL have port wr_addr  input  LOGSIZE  write address.
REQ-008 SHALL have port wr_data  input  BITS  write data.
REQ-009 SHALL have port wr_ack  output  1  the write is performed this cycle.
REQ-010 SHALL have port rd_req  input  1  the reader requests one read this cycle.
REQ-011 SHALL have port rd_addr  input  LOGSIZE  read address.
REQ-012 SHALL have port rd_ack  output  1  the read is issued this cycle.
REQ-013 SHALL have port rd_valid  output  1  rd_data holds the result of the read acked in the previous cycle.
REQ-014 SHALL have port rd_data  output  BITS  read result.
REQ-015 SHALL have ports mem_addr (output LOGSIZE), mem_din (output BITS), mem_we (output 1) and mem_dout (input BITS), connecting to a single-port block RAM whose read latency is 1 cycle.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse on a write to address SIZE-1.
REQ-017 SHALL have port frame_count  output  8  completed-frame counter.

Function
REQ-018 SHALL grant at most one requester per cycle.
- wr_ack and rd_ack are combinational from the requests and the round-robin state.
- Both acks SHALL never be high together.
REQ-019 SHALL grant the requester alone when only one requests.
REQ-020 SHALL resolve contention (both requesting) round-robin: the grant goes to the requester not granted at the most recent contention.
REQ-021 SHALL update the round-robin state only on contention cycles; the reset state gives the first contention to the writer.
REQ-022 SHALL, on a write grant, drive:
- mem_addr=wr_addr
- mem_din=wr_data
- mem_we=1, except mem_we=0 when wr_addr>=SIZE.
REQ-023 SHALL, on a read grant or when idle, drive mem_addr=rd_addr and mem_we=0; mem_din SHALL hold wr_data.
REQ-024 SHALL raise rd_valid exactly one cycle after a rd_ack cycle, and SHALL hold it low otherwise.
REQ-025 SHALL drive rd_data=mem_dout combinationally; it is meaningful only while rd_valid=1.
REQ-026 SHALL ack a write to an out-of-range address (>=SIZE) normally but SHALL NOT modify memory.
REQ-027 SHALL ack a read of an out-of-range address; the returned data is undefined.
REQ-028 SHALL pulse frame_done one cycle after an acked write with wr_addr==SIZE-1.
REQ-029 SHALL increment frame_count on the same edge that raises frame_done, wrapping 255->0.
REQ-030 SHALL let a requester denied by contention keep its request asserted; it is acked the next cycle at the latest (no starvation beyond 1 cycle).
REQ-031 SHALL treat a read and a write to the same address acked in consecutive cycles in grant order; the read returns the data written earlier.

Reset
REQ-032 SHALL, while reset=1, force:
- wr_ack=0, rd_ack=0, mem_we=0
- rd_valid=0, frame_done=0, frame_count=0
- round-robin state to favour the writer.
REQ-033 SHALL drop any read acked in the cycle reset is sampled high (no rd_valid follows).
REQ-034 SHALL ignore requests presented during reset; they are not acked.

Structure
REQ-035 SHALL take the grant encoding (GNT_WR, GNT_RD) and the default SIZE/LOGSIZE/BITS constants from the shared package mem_pkg.
REQ-036 SHALL place the two-input round-robin decision, with its state bit, in sub-module rr_arb2; the address/data muxing, rd_valid pipeline and frame counter stay in bram_arbiter.

Verification
REQ-037 Writer only: wr_req=1, wr_addr=5, wr_data=1 for one cycle -> wr_ack=1, mem_we=1, mem_addr=5 that cycle.
REQ-038 Read after write: rd_req=1, rd_addr=5 after the write to address 5 -> rd_ack that cycle; rd_valid=1 and rd_data=1 the next cycle.
REQ-039 Contention: both requests held 4 cycles from reset -> acks in order WR, RD, WR, RD; rd_valid high in cycles 3 and 5.
REQ-040 Frame end: acked write to address SIZE-1 repeated 256 times -> 256 frame_done pulses; frame_count returns to 0.
REQ-041 Out-of-range write: wr_addr=SIZE, wr_req=1 -> wr_ack=1, mem_we=0, no frame_done.
REQ-042 Reset mid-read: rd_ack in cycle N with reset=1 sampled at the edge ending cycle N -> rd_valid=0 in cycle N+1; frame_count=0.
